// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment receive path.
// Glyphs are gfedcba with bit0 = segment a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] value;
    } glyph_dec_t;

    // Digit selects are padded to 8 bits so one helper serves every NDIG.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Purpose: map a 7-segment pattern back to its hex value, flagging blank and unknown glyphs.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the pattern.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] value
);

    glyph_dec_t dec;

    always_comb begin
        dec = '0;
        dec.hit = 1'b1;
        case (pattern)
            SEG_0:     dec.value = 4'h0;
            SEG_1:     dec.value = 4'h1;
            SEG_2:     dec.value = 4'h2;
            SEG_3:     dec.value = 4'h3;
            SEG_4:     dec.value = 4'h4;
            SEG_5:     dec.value = 4'h5;
            SEG_6:     dec.value = 4'h6;
            SEG_7:     dec.value = 4'h7;
            SEG_8:     dec.value = 4'h8;
            SEG_9:     dec.value = 4'h9;
            SEG_A:     dec.value = 4'hA;
            SEG_B:     dec.value = 4'hB;
            SEG_C:     dec.value = 4'hC;
            SEG_D:     dec.value = 4'hD;
            SEG_E:     dec.value = 4'hE;
            SEG_F:     dec.value = 4'hF;
            SEG_BLANK: begin
                dec.hit   = 1'b0;
                dec.blank = 1'b1;
            end
            default:   dec.hit = 1'b0;
        endcase
    end

    assign hit   = dec.hit;
    assign blank = dec.blank;
    assign value = dec.value;

endmodule

// File: rtl/seg7_display_rx.sv
// Purpose: sample a multiplexed 7-segment bus, qualify by stability, decode into per-digit shadow registers.
// Latency: pattern sampled at edge 0 and held yields its update/err pulse after edge STABLE_CYCLES.
// Backpressure: none; the monitor always accepts, pulses are single-cycle and never back to back.
module seg7_display_rx
    import seg7_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     digit_valid,
    output logic                upd_valid,
    output logic [2:0]          upd_idx,
    output logic [3:0]          upd_val,
    output logic                upd_blank,
    output logic                err
);

    localparam int            SW      = NDIG + 7;
    localparam int            CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]   raw_smp;
    logic [SW-1:0]   sample_q;
    logic [SW-1:0]   held_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_nxt;
    logic            committed_q;
    logic            same;
    logic            commit;

    logic [NDIG-1:0] held_sel;
    logic [6:0]      held_seg;
    logic [7:0]      sel8;
    logic [2:0]      slot_idx;

    logic            dec_hit;
    logic            dec_blank;
    logic [3:0]      dec_value;

    logic [3:0]      slot_val_q [NDIG];
    logic [NDIG-1:0] slot_vld_q;
    logic [3:0]      cur_val;
    logic            cur_vld;
    logic            do_upd;
    logic            do_blank;
    logic            do_err;

    logic            upd_valid_q;
    logic            err_q;
    logic            upd_blank_q;
    logic [2:0]      upd_idx_q;
    logic [3:0]      upd_val_q;

    assign raw_smp  = (ACTIVE_LOW != 0) ? ~{dig_sel, seg_in} : {dig_sel, seg_in};
    assign same     = (sample_q == held_q);
    assign held_sel = held_q[SW-1:7];
    assign held_seg = held_q[6:0];

    always_comb begin
        cnt_nxt = '0;
        if (same) begin
            cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_comb begin
        sel8 = 8'd0;
        sel8[NDIG-1:0] = held_sel;
    end

    assign slot_idx = onehot_to_idx(sel8);

    seg7_glyph_decode u_decode (
        .pattern (held_seg),
        .hit     (dec_hit),
        .blank   (dec_blank),
        .value   (dec_value)
    );

    always_comb begin
        cur_val = 4'd0;
        cur_vld = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (held_sel[i]) begin
                cur_val = slot_val_q[i];
                cur_vld = slot_vld_q[i];
            end
        end
    end

    // The sample matching the held copy is the stable pattern being qualified.
    assign commit   = same && (cnt_nxt == CNT_MAX) && !committed_q && is_onehot(sel8);
    assign do_upd   = commit && dec_hit && (!cur_vld || (cur_val != dec_value));
    assign do_blank = commit && dec_blank && cur_vld;
    assign do_err   = commit && !dec_hit && !dec_blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q    <= '0;
            held_q      <= '0;
            cnt_q       <= '0;
            committed_q <= 1'b0;
        end else begin
            sample_q <= raw_smp;
            held_q   <= sample_q;
            cnt_q    <= cnt_nxt;
            if (!same) begin
                committed_q <= 1'b0;
            end else if (commit) begin
                committed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                slot_val_q[i] <= 4'd0;
            end
            slot_vld_q  <= '0;
            upd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            upd_blank_q <= 1'b0;
            upd_idx_q   <= 3'd0;
            upd_val_q   <= 4'd0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (held_sel[i] && do_upd) begin
                    slot_val_q[i] <= dec_value;
                    slot_vld_q[i] <= 1'b1;
                end else if (held_sel[i] && do_blank) begin
                    slot_vld_q[i] <= 1'b0;
                end
            end
            upd_valid_q <= do_upd || do_blank;
            err_q       <= do_err;
            if (do_upd || do_blank || do_err) begin
                upd_idx_q <= slot_idx;
            end
            // On err only the index moves; value/blank keep describing the last update.
            if (do_upd || do_blank) begin
                upd_val_q   <= do_upd ? dec_value : 4'd0;
                upd_blank_q <= do_blank;
            end
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_digits
        assign digits[4*g +: 4] = slot_val_q[g];
    end

    assign digit_valid = slot_vld_q;
    assign upd_valid   = upd_valid_q;
    assign err         = err_q;
    assign upd_idx     = upd_idx_q;
    assign upd_val     = upd_val_q;
    assign upd_blank   = upd_blank_q;

endmodule
